// File: rtl/safe_pkg.sv
// Shared key codes, debounce state encoding and small helpers for the safe keypad path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package safe_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  localparam logic [1:0] DB_IDLE         = 2'd0;
  localparam logic [1:0] DB_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] DB_HELD         = 2'd2;
  localparam logic [1:0] DB_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = DB_IDLE,
    ST_PRESS_WAIT   = DB_PRESS_WAIT,
    ST_HELD         = DB_HELD,
    ST_RELEASE_WAIT = DB_RELEASE_WAIT
  } db_state_t;

  // Digits 0-9, star and hash are real keys; C, D, E and F all mean "no key".
  function automatic logic is_valid_key(input logic [3:0] code);
    return (code <= 4'h9) || (code == KEY_STAR) || (code == KEY_HASH);
  endfunction

  // Ceiling log2, used for counter and pointer widths (callers pass values >= 2).
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead FIFO holding debounced key events; head visible from registered state.
// Latency: a push is visible at the head one cycle later; pop takes effect on the next edge.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module key_event_fifo
  import safe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage array; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_filter.sv
// Resynchronises and debounces raw keypad codes, emitting one buffered event per press.
// Latency: key steady from cycle t gives key_valid at t+DEBOUNCE_CYCLES+3 when the FIFO is empty.
// Backpressure: valid/ready on the FIFO head; events arriving while full are dropped and flagged sticky.
module key_event_filter
  import safe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw_key,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int              CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam int              FPTR_W   = clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       key_s;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [3:0]       cand;
  logic [3:0]       cand_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             push_vld;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       head_dat;
  logic [FPTR_W:0]  fifo_count;

  // Two-flop resynchroniser; idles at "no key".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= KEY_NONE;
      sync2 <= KEY_NONE;
    end else begin
      sync1 <= raw_key;
      sync2 <= sync1;
    end
  end

  // Invalid codes are folded into "no key" after the synchroniser, keeping sync1->sync2 logic-free.
  assign key_s = is_valid_key(sync2) ? sync2 : KEY_NONE;

  // Debounce state, candidate key and stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cand  <= KEY_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce next-state: a press or release must be stable for the full count to be accepted.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    push_vld  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_s != KEY_NONE) begin
          state_nxt = ST_PRESS_WAIT;
          cand_nxt  = key_s;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (key_s == cand) begin
          if (cnt == CNT_LAST) begin
            push_vld  = 1'b1;
            state_nxt = ST_HELD;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (key_s == KEY_NONE) begin
          state_nxt = ST_IDLE;
        end else begin
          cand_nxt = key_s;
          cnt_nxt  = '0;
        end
      end
      ST_HELD: begin
        if (key_s != cand) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key_s == KEY_NONE) begin
          if (cnt == CNT_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (key_s == cand) begin
          state_nxt = ST_HELD;
        end else begin
          // Rolling onto another key never yields an event until everything is released.
          cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign key_held = (state == ST_HELD) || (state == ST_RELEASE_WAIT);

  assign fifo_pop  = key_valid && key_ready;
  assign key_valid = !fifo_empty;
  assign key_code  = (fifo_count == '0) ? KEY_NONE : head_dat;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_vld),
    .push_dat (cand),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Sticky drop flag: only a push refused by a full FIFO (no simultaneous pop) sets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_vld && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

endmodule
